tcdm_port_rr_arbiter: RTL and testbench

- Shares one TCDM master port between NB_REQ requesters, e.g. the AXI-to-memory converter channels and the cluster DMA, using round-robin arbitration.
- Tracks outstanding requests in an in-order ID FIFO so each r_valid/r_rdata is returned to the requester that issued it.
- Sits between the requester-side TCDM buses and one logarithmic-interconnect master port.
- Stalls issue when MAX_OUTSTANDING responses are pending.

---
 rtl/tcdm_port_rr_arbiter.sv | 98 +++++++++
 tb/tb_tcdm_port_rr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tcdm_port_rr_arbiter.sv
// tcdm_port_rr_arbiter: round-robin share of one TCDM master port, with in-order response routing.
module tcdm_port_rr_arbiter #(
    parameter int NB_REQ          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] add_i,
    input  logic [NB_REQ-1:0]            wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         req_o,
    output logic [ADDR_WIDTH-1:0]        add_o,
    output logic                         wen_o,
    output logic [DATA_WIDTH-1:0]        wdata_o,
    output logic [DATA_WIDTH/8-1:0]      be_o,
    input  logic                         gnt_i,
    input  logic                         r_valid_i,
    input  logic [DATA_WIDTH-1:0]        r_rdata_i,
    output logic                         busy_o
);
    localparam int IDW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW  = DATA_WIDTH / 8;

    logic [IDW-1:0] rr_ptr, winner, sel, head;
    logic [IDW-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, push, pop;

    // Scan downward so the index closest to rr_ptr is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            j = (j >= NB_REQ) ? j - NB_REQ : j;
            if (req_i[j]) winner = IDW'(j);
        end
    end

    assign full  = count == CW'(MAX_OUTSTANDING);
    assign req_o = (|req_i) & ~full;
    assign sel   = req_o ? winner : '0;
    assign push  = req_o & gnt_i;
    assign pop   = r_valid_i & (count != '0);
    assign head  = id_fifo[rd_ptr];

    always_comb begin
        add_o     = add_i[ADDR_WIDTH-1:0];
        wen_o     = wen_i[0];
        wdata_o   = wdata_i[DATA_WIDTH-1:0];
        be_o      = be_i[BW-1:0];
        gnt_o     = '0;
        r_valid_o = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (sel == IDW'(i)) begin
                add_o   = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                wen_o   = wen_i[i];
                wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                be_o    = be_i[i*BW +: BW];
            end
            gnt_o[i]     = push & (winner == IDW'(i));
            r_valid_o[i] = pop & (head == IDW'(i));
        end
    end

    assign r_rdata_o = r_rdata_i;
    assign busy_o    = (count != '0) | (|req_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                rr_ptr <= (winner == IDW'(NB_REQ - 1)) ? '0 : winner + 1'b1;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_fifo[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_tcdm_port_rr_arbiter.sv
// tb_tcdm_port_rr_arbiter: directed bench with a scoreboard of granted requester IDs.
module tb_tcdm_port_rr_arbiter;
    logic        clk_i = 0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [63:0] add_i;
    logic [1:0]  wen_i;
    logic [63:0] wdata_i;
    logic [7:0]  be_i;
    logic [1:0]  gnt_o, r_valid_o;
    logic [31:0] r_rdata_o;
    logic        req_o, wen_o;
    logic [31:0] add_o, wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i, r_valid_i;
    logic [31:0] r_rdata_i;
    logic        busy_o;

    int checks = 0;
    int failures = 0;
    int m_rr = 0;
    int q[$];
    logic [1:0] last_gnt, last_rv;

    tcdm_port_rr_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .req_o(req_o), .add_o(add_o), .wen_o(wen_o),
        .wdata_o(wdata_o), .be_o(be_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
        .r_rdata_i(r_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr_win(input logic [1:0] r, input int p);
        for (int k = 0; k < 2; k++)
            if (r[(p + k) % 2]) return (p + k) % 2;
        return 0;
    endfunction

    // One clock: drive, check combinational outputs against the model, then advance the model.
    task automatic cyc(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] d);
        int w, s;
        logic ereq, pop;
        logic [1:0] egnt, erv;
        req_i = r; gnt_i = g; r_valid_i = rv; r_rdata_i = d;
        #1;
        w    = rr_win(r, m_rr);
        ereq = (|r) && (q.size() < 2);
        s    = ereq ? w : 0;
        egnt = (ereq && g) ? 2'(2'b01 << w) : 2'b00;
        pop  = rv && (q.size() > 0);
        erv  = pop ? 2'(2'b01 << q[0]) : 2'b00;
        chk("req_o", 64'(req_o), 64'(ereq));
        chk("gnt_o", 64'(gnt_o), 64'(egnt));
        chk("r_valid_o", 64'(r_valid_o), 64'(erv));
        chk("r_rdata_o", 64'(r_rdata_o), 64'(d));
        chk("busy_o", 64'(busy_o), 64'((q.size() != 0) || (|r)));
        chk("add_o", 64'(add_o), 64'(add_i[s*32 +: 32]));
        chk("wen_o", 64'(wen_o), 64'(wen_i[s]));
        chk("wdata_o", 64'(wdata_o), 64'(wdata_i[s*32 +: 32]));
        chk("be_o", 64'(be_o), 64'(be_i[s*4 +: 4]));
        last_gnt = gnt_o;
        last_rv  = r_valid_o;
        @(posedge clk_i);
        if (pop) void'(q.pop_front());
        if (ereq && g) begin
            q.push_back(w);
            m_rr = (w + 1) % 2;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1; req_i = 0; gnt_i = 0; r_valid_i = 0; r_rdata_i = 0;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        q.delete();
        m_rr = 0;
    endtask

    initial begin
        add_i   = {32'h2000_0004, 32'h1000_0000};
        wen_i   = 2'b11;
        wdata_i = {32'h2222_2222, 32'h1111_1111};
        be_i    = 8'hFF;
        do_reset();
        cyc(2'b00, 0, 0, 32'h0);
        chk("reset_req_o", 64'(req_o), 64'(0));
        chk("reset_busy", 64'(busy_o), 64'(0));

        // Alternating grants with one-cycle-late responses.
        cyc(2'b11, 1, 0, 32'h0);        chk("t1_g0", 64'(last_gnt), 64'(2'b01));
        cyc(2'b11, 1, 1, 32'hA1);       chk("t1_g1", 64'(last_gnt), 64'(2'b10));
        chk("t1_rv1", 64'(last_rv), 64'(2'b01));
        cyc(2'b11, 1, 1, 32'hA2);       chk("t1_g2", 64'(last_gnt), 64'(2'b01));
        chk("t1_rv2", 64'(last_rv), 64'(2'b10));
        cyc(2'b11, 1, 1, 32'hA3);       chk("t1_g3", 64'(last_gnt), 64'(2'b10));
        cyc(2'b00, 0, 1, 32'hA4);       chk("t1_rv4", 64'(last_rv), 64'(2'b10));

        // Fill the FIFO from requester 0, then pop while full.
        cyc(2'b01, 1, 0, 32'h0);
        cyc(2'b01, 1, 0, 32'h0);
        cyc(2'b01, 1, 0, 32'h0);        chk("t2_full_gnt", 64'(last_gnt), 64'(2'b00));
        chk("t2_full_req", 64'(req_o), 64'(0));
        cyc(2'b01, 1, 1, 32'hB1);       chk("t3_pop_nogrant", 64'(last_gnt), 64'(2'b00));
        chk("t3_rv", 64'(last_rv), 64'(2'b01));
        cyc(2'b01, 1, 0, 32'h0);        chk("t3_regrant", 64'(last_gnt), 64'(2'b01));
        cyc(2'b00, 0, 1, 32'hB2);       chk("t2_rv_a", 64'(last_rv), 64'(2'b01));
        cyc(2'b00, 0, 1, 32'hB3);       chk("t2_rv_b", 64'(last_rv), 64'(2'b01));

        // Responses with nothing outstanding are dropped.
        cyc(2'b00, 0, 1, 32'hC1);       chk("t4_drop", 64'(last_rv), 64'(2'b00));
        chk("t4_busy0", 64'(busy_o), 64'(0));
        cyc(2'b10, 0, 1, 32'hC2);       chk("t4_busy1", 64'(busy_o), 64'(1));

        // Write from requester 1 with requester 0 idle.
        add_i[63:32] = 32'h1000_0040; wen_i[1] = 1'b0; be_i[7:4] = 4'b0011; wdata_i[63:32] = 32'hDEADBEEF;
        req_i = 2'b10; gnt_i = 1; r_valid_i = 0;
        #1;
        chk("t5_add", 64'(add_o), 64'h1000_0040);
        chk("t5_wen", 64'(wen_o), 64'(0));
        chk("t5_be", 64'(be_o), 64'(4'b0011));
        chk("t5_wdata", 64'(wdata_o), 64'hDEADBEEF);
        cyc(2'b10, 1, 0, 32'h0);        chk("t5_gnt", 64'(last_gnt), 64'(2'b10));
        cyc(2'b00, 0, 1, 32'hD1);       chk("t5_rv", 64'(last_rv), 64'(2'b10));
        wen_i = 2'b11;

        // Mid-operation reset drops pending responses.
        cyc(2'b10, 1, 0, 32'h0);
        cyc(2'b10, 1, 0, 32'h0);
        do_reset();
        cyc(2'b00, 0, 1, 32'hE1);       chk("t6_drop_a", 64'(last_rv), 64'(2'b00));
        cyc(2'b00, 0, 1, 32'hE2);       chk("t6_drop_b", 64'(last_rv), 64'(2'b00));
        chk("t6_busy", 64'(busy_o), 64'(0));

        // Leave rr_ptr at 1, reset, and confirm arbitration restarts at requester 0.
        cyc(2'b01, 1, 0, 32'h0);
        do_reset();
        cyc(2'b11, 1, 0, 32'h0);        chk("t6_rr_restart", 64'(last_gnt), 64'(2'b01));
        cyc(2'b00, 0, 1, 32'hF1);       chk("t6_rv", 64'(last_rv), 64'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
